// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared LSU definitions: load/store type codes, strobe patterns, FSM states
// and the alignment rule used by the optional misalignment check.
package ysyx_22041211_lsu_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } store_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } lsu_state_e;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Halfword accesses need an even address, word accesses a word-aligned one.
  function automatic logic is_misaligned(input logic [2:0] load_type,
                                         input logic [1:0] store_type,
                                         input logic [1:0] lane);
    logic w_half;
    logic w_word;
    w_half = (load_type == LD_LH) || (load_type == LD_LHU) || (store_type == ST_SH);
    w_word = (load_type == LD_LW) || (store_type == ST_SW);
    return (w_half && lane[0]) || (w_word && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Byte-lane steering for the LSU: picks and extends the loaded byte/half from
// the read word, and replicates store data across lanes with matching strobes.
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [1:0]          i_lane,
  input  logic [2:0]          i_load_type,
  input  logic [1:0]          i_store_type,
  input  logic [DATA_LEN-1:0] i_rdata,
  input  logic [DATA_LEN-1:0] i_wdata,
  output logic [DATA_LEN-1:0] o_load_data,
  output logic [DATA_LEN-1:0] o_store_data,
  output logic [3:0]          o_wstrb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword; a half starting in lane 3 only has its low byte.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (i_lane)
      2'd0: begin
        w_byte = i_rdata[7:0];
        w_half = i_rdata[15:0];
      end
      2'd1: begin
        w_byte = i_rdata[15:8];
        w_half = i_rdata[23:8];
      end
      2'd2: begin
        w_byte = i_rdata[23:16];
        w_half = i_rdata[31:16];
      end
      default: begin
        w_byte = i_rdata[31:24];
        w_half = {8'h00, i_rdata[31:24]};
      end
    endcase
  end

  // Sign- or zero-extend the selected data into the register-write value.
  always_comb begin
    o_load_data = '0;
    case (i_load_type)
      LD_LB:   o_load_data = {{(DATA_LEN-8){w_byte[7]}}, w_byte};
      LD_LH:   o_load_data = {{(DATA_LEN-16){w_half[15]}}, w_half};
      LD_LW:   o_load_data = i_rdata;
      LD_LBU:  o_load_data = {{(DATA_LEN-8){1'b0}}, w_byte};
      LD_LHU:  o_load_data = {{(DATA_LEN-16){1'b0}}, w_half};
      default: o_load_data = '0;
    endcase
  end

  // Replicate store data on every lane and enable only the addressed bytes.
  always_comb begin
    o_store_data = '0;
    o_wstrb      = STRB_NONE;
    case (i_store_type)
      ST_SB: begin
        o_store_data = {(DATA_LEN/8){i_wdata[7:0]}};
        o_wstrb      = STRB_BYTE << i_lane;
      end
      ST_SH: begin
        o_store_data = {(DATA_LEN/16){i_wdata[15:0]}};
        o_wstrb      = STRB_HALF << i_lane;
      end
      ST_SW: begin
        o_store_data = i_wdata;
        o_wstrb      = STRB_WORD;
      end
      default: begin
        o_store_data = '0;
        o_wstrb      = STRB_NONE;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit between EX and WB. ALU results pass through in one cycle;
// memory ops run a single outstanding req/gnt/rvalid transaction.
// Optional: define YSYX_22041211_LSU_MISALIGN_CHK_EN to trap misaligned
// half/word accesses locally and report them on err_o.
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic                mem_wen_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [1:0]          store_type_i,
  input  logic [2:0]          load_type_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
  ,
  output logic                err_o
`endif
);

  lsu_state_e r_state;
  lsu_state_e w_next_state;

  logic                w_transfer;
  logic                w_mem_op;
  logic                w_misalign;
  logic                w_start_mem;
  logic                w_complete;
  logic                w_is_load;
  logic [DATA_LEN-1:0] w_load_data;
  logic [3:0]          w_wstrb;

  logic [DATA_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_st_wdata;
  logic [2:0]          r_load_type;
  logic [1:0]          r_store_type;
  logic                r_we;
  logic                r_op_wd;
  logic [4:0]          r_op_wreg;

  logic                r_valid;
  logic                r_wd;
  logic [4:0]          r_wreg;
  logic [DATA_LEN-1:0] r_wdata;

  assign ready_o     = (r_state == S_IDLE) && (!r_valid || ready_i);
  assign w_transfer  = valid_i && ready_o;
  assign w_mem_op    = (load_type_i != LD_NONE) || mem_wen_i;
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
  assign w_misalign  = w_mem_op &&
                       is_misaligned(load_type_i, mem_wen_i ? store_type_i : ST_NONE,
                                     alu_result_i[1:0]);
`else
  assign w_misalign  = 1'b0;
`endif
  assign w_start_mem = w_transfer && w_mem_op && !w_misalign;
  assign w_is_load   = (r_load_type != LD_NONE);

  // FSM state register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, request strobe and completion detect; rvalid is only honoured after a grant.
  always_comb begin
    w_next_state = r_state;
    w_complete   = 1'b0;
    mem_req_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_mem) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            w_next_state = S_IDLE;
            w_complete   = 1'b1;
          end else begin
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_next_state = S_IDLE;
          w_complete   = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Capture the memory op on transfer so address, data and strobes hold until grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= '0;
      r_st_wdata   <= '0;
      r_load_type  <= LD_NONE;
      r_store_type <= ST_NONE;
      r_we         <= 1'b0;
      r_op_wd      <= 1'b0;
      r_op_wreg    <= 5'd0;
    end else if (w_start_mem) begin
      r_addr       <= alu_result_i;
      r_st_wdata   <= mem_wdata_i;
      r_load_type  <= load_type_i;
      r_store_type <= mem_wen_i ? store_type_i : ST_NONE;
      r_we         <= mem_wen_i;
      r_op_wd      <= wd_i;
      r_op_wreg    <= wreg_i;
    end
  end

  ysyx_22041211_lsu_align #(
    .DATA_LEN(DATA_LEN)
  ) u_align (
    .i_lane       (r_addr[1:0]),
    .i_load_type  (r_load_type),
    .i_store_type (r_store_type),
    .i_rdata      (mem_rdata_i),
    .i_wdata      (r_st_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (mem_wdata_o),
    .o_wstrb      (w_wstrb)
  );

  assign mem_addr_o  = {r_addr[DATA_LEN-1:2], 2'b00};
  assign mem_we_o    = mem_req_o && r_we;
  assign mem_wstrb_o = mem_req_o ? w_wstrb : STRB_NONE;

`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
  logic r_err;
  assign err_o = r_err;
`endif

  // WB output register: loaded by a pass-through/trapped op or a memory completion, held until consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_wd    <= 1'b0;
      r_wreg  <= 5'd0;
      r_wdata <= '0;
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
      r_err   <= 1'b0;
`endif
    end else if (w_transfer && (!w_mem_op || w_misalign)) begin
      r_valid <= 1'b1;
      r_wd    <= wd_i && !w_misalign;
      r_wreg  <= wreg_i;
      r_wdata <= w_misalign ? '0 : alu_result_i;
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
      r_err   <= w_misalign;
`endif
    end else if (w_complete) begin
      r_valid <= 1'b1;
      r_wd    <= w_is_load && r_op_wd;
      r_wreg  <= r_op_wreg;
      r_wdata <= w_is_load ? w_load_data : '0;
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
      r_err   <= 1'b0;
`endif
    end else if (ready_i) begin
      r_valid <= 1'b0;
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
      r_err   <= 1'b0;
`endif
    end
  end

  assign valid_o = r_valid;
  assign wd_o    = r_wd;
  assign wreg_o  = r_wreg;
  assign wdata_o = r_wdata;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Self-checking bench for ysyx_22041211_lsu: directed scenarios followed by
// randomized transactions compared against an arithmetic reference model.
module tb_ysyx_22041211_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, wd_i, mem_wen_i;
  logic [4:0]  wreg_i;
  logic [31:0] alu_result_i, mem_wdata_i;
  logic [1:0]  store_type_i;
  logic [2:0]  load_type_i;
  logic        valid_o, ready_i, wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
  logic        err_o;
`endif

  int checks = 0;
  int errors = 0;

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .alu_result_i (alu_result_i),
    .mem_wen_i    (mem_wen_i),
    .mem_wdata_i  (mem_wdata_i),
    .store_type_i (store_type_i),
    .load_type_i  (load_type_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
    ,
    .err_o        (err_o)
`endif
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: load extraction from the addressed lane.
  function automatic logic [31:0] refLoad(input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] sh;
    int b, h;
    sh = rdata >> (8 * addr[1:0]);
    b  = int'(sh & 32'hFF);
    h  = int'(sh & 32'hFFFF);
    case (lt)
      3'd1:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd2:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd3:    return rdata;
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] refStrb(input logic [1:0] st, input logic [31:0] addr);
    case (st)
      2'd1:    return 4'((32'd1 << addr[1:0]) & 32'hF);
      2'd2:    return 4'((32'd3 << addr[1:0]) & 32'hF);
      2'd3:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] refStoreData(input logic [1:0] st, input logic [31:0] wdata);
    case (st)
      2'd1:    return (wdata & 32'hFF) * 32'h01010101;
      2'd2:    return (wdata & 32'hFFFF) * 32'h00010001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic refMisalign(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] addr);
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
    int lane;
    lane = int'(addr % 4);
    if ((lt == 3'd2 || lt == 3'd5 || st == 2'd2) && (lane % 2 != 0)) return 1'b1;
    if ((lt == 3'd3 || st == 2'd3) && (lane != 0)) return 1'b1;
    return 1'b0;
`else
    return (lt == 3'd7) && (st == 2'd0) && (addr == 32'hFFFF_FFFF);
`endif
  endfunction

  // Present one op for a single transfer cycle; the LSU must be ready.
  task automatic applyStimulus(input logic [2:0] lt, input logic [1:0] st, input logic wen,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic wd, input logic [4:0] wreg);
    valid_i      = 1'b1;
    load_type_i  = lt;
    store_type_i = st;
    mem_wen_i    = wen;
    alu_result_i = addr;
    mem_wdata_i  = wdata;
    wd_i         = wd;
    wreg_i       = wreg;
    checkOutput("ready_before_transfer", ready_o, 1);
    tick();
    valid_i      = 1'b0;
    load_type_i  = 3'd0;
    store_type_i = 2'd0;
    mem_wen_i    = 1'b0;
    alu_result_i = $urandom;
    mem_wdata_i  = $urandom;
  endtask

  // Act as memory: grant after gntDelay cycles, return data rvDelay cycles after grant (0 = same cycle).
  task automatic runMemTxn(input int gntDelay, input int rvDelay, input logic [31:0] rdata);
    for (int i = 0; i < gntDelay; i++) begin
      checkOutput("req_held", mem_req_o, 1);
      tick();
    end
    checkOutput("req_at_gnt", mem_req_o, 1);
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = (rvDelay == 0);
    mem_rdata_i  = (rvDelay == 0) ? rdata : $urandom;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    for (int i = 0; i < rvDelay; i++) begin
      checkOutput("wait_req_low", mem_req_o, 0);
      checkOutput("wait_no_valid", valid_o, 0);
      if (i == rvDelay - 1) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
      end
      tick();
      mem_rvalid_i = 1'b0;
    end
    mem_rdata_i = $urandom;
  endtask

  // Check the WB output, stall it for a few cycles, then consume it.
  task automatic expectOutput(input string tag, input logic expWd, input logic [4:0] expWreg,
                              input logic [31:0] expWdata, input logic checkData,
                              input logic expErr, input int stall);
    checkOutput({tag, "_valid"}, valid_o, 1);
    checkOutput({tag, "_wd"}, wd_o, expWd);
    checkOutput({tag, "_req_idle"}, mem_req_o, 0);
    if (checkData) begin
      checkOutput({tag, "_wreg"}, wreg_o, expWreg);
      checkOutput({tag, "_wdata"}, wdata_o, expWdata);
    end
`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
    checkOutput({tag, "_err"}, err_o, expErr);
`else
    if (expErr) checkOutput({tag, "_err_unexpected"}, 0, 1);
`endif
    ready_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput({tag, "_hold_valid"}, valid_o, 1);
      checkOutput({tag, "_hold_ready"}, ready_o, 0);
      if (checkData) checkOutput({tag, "_hold_wdata"}, wdata_o, expWdata);
    end
    ready_i = 1'b1;
    tick();
    checkOutput({tag, "_consumed"}, valid_o, 0);
  endtask

  // Main sequence: reset, directed scenarios, then randomized traffic.
  initial begin
    rst = 1'b0;
    valid_i = 0; wd_i = 0; wreg_i = 0; alu_result_i = 0; mem_wen_i = 0; mem_wdata_i = 0;
    store_type_i = 0; load_type_i = 0; ready_i = 1; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_wd", wd_o, 0);
    checkOutput("rst_wreg", wreg_o, 0);
    checkOutput("rst_wdata", wdata_o, 0);
    checkOutput("rst_req", mem_req_o, 0);
    checkOutput("rst_we", mem_we_o, 0);
    checkOutput("rst_wstrb", mem_wstrb_o, 0);
    checkOutput("rst_ready", ready_o, 1);
    rst = 1'b1;
    tick();

    // Pass-through ALU result.
    applyStimulus(3'd0, 2'd0, 1'b0, 32'h12345678, 32'h0, 1'b1, 5'd5);
    expectOutput("alu", 1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 0);

    // LB with grant and data together one cycle after transfer.
    applyStimulus(3'd1, 2'd0, 1'b0, 32'h80000003, 32'h0, 1'b1, 5'd7);
    checkOutput("lb_addr", mem_addr_o, 32'h80000000);
    checkOutput("lb_we", mem_we_o, 0);
    runMemTxn(0, 0, 32'h80FF0000);
    expectOutput("lb", 1'b1, 5'd7, 32'hFFFFFF80, 1'b1, 1'b0, 0);

    // LHU with grant delayed three cycles.
    applyStimulus(3'd5, 2'd0, 1'b0, 32'h80000002, 32'h0, 1'b1, 5'd9);
    checkOutput("lhu_addr", mem_addr_o, 32'h80000000);
    runMemTxn(3, 1, 32'hBEEF1234);
    expectOutput("lhu", 1'b1, 5'd9, 32'h0000BEEF, 1'b1, 1'b0, 0);

    // SB replicates the byte and strobes lane 1.
    applyStimulus(3'd0, 2'd1, 1'b1, 32'h80000001, 32'h000000AB, 1'b1, 5'd3);
    checkOutput("sb_addr", mem_addr_o, 32'h80000000);
    checkOutput("sb_strb", mem_wstrb_o, 4'b0010);
    checkOutput("sb_wdata", mem_wdata_o, 32'hABABABAB);
    checkOutput("sb_we", mem_we_o, 1);
    runMemTxn(0, 0, 32'h0);
    expectOutput("sb", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 0);

    // Back-pressure for five cycles after a completion.
    applyStimulus(3'd0, 2'd0, 1'b0, 32'h0BADF00D, 32'h0, 1'b1, 5'd12);
    expectOutput("stall", 1'b1, 5'd12, 32'h0BADF00D, 1'b1, 1'b0, 5);

    // Asynchronous reset clears a pending output without waiting for a clock edge.
    applyStimulus(3'd0, 2'd0, 1'b0, 32'hCAFE0000, 32'h0, 1'b1, 5'd21);
    ready_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_valid", valid_o, 0);
    checkOutput("arst_wdata", wdata_o, 0);
    checkOutput("arst_wreg", wreg_o, 0);
    @(negedge clk);
    rst = 1'b1;
    ready_i = 1'b1;
    tick();

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    applyStimulus(3'd3, 2'd0, 1'b0, 32'h80000010, 32'h0, 1'b1, 5'd4);
    checkOutput("rstwait_req", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    checkOutput("rstwait_in_wait_req", mem_req_o, 0);
    checkOutput("rstwait_in_wait_ready", ready_o, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstwait_req_low", mem_req_o, 0);
    checkOutput("rstwait_valid_low", valid_o, 0);
    checkOutput("rstwait_idle", ready_o, 1);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55AA55AA;
    tick();
    mem_rvalid_i = 1'b0;
    checkOutput("late_rvalid_valid", valid_o, 0);
    checkOutput("late_rvalid_ready", ready_o, 1);

`ifdef YSYX_22041211_LSU_MISALIGN_CHK_EN
    // Misaligned LW is trapped locally.
    applyStimulus(3'd3, 2'd0, 1'b0, 32'h80000002, 32'h0, 1'b1, 5'd6);
    checkOutput("mis_no_req", mem_req_o, 0);
    expectOutput("mis_lw", 1'b0, 5'd6, 32'h0, 1'b0, 1'b1, 1);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [2:0]  lt;
      logic [1:0]  st;
      logic [31:0] addr, wdata, rdata, expData;
      logic        wd, mis, expWd;
      logic [4:0]  wreg;
      kind  = int'($urandom_range(0, 2));
      lt    = (kind == 1) ? 3'($urandom_range(1, 5)) : 3'd0;
      st    = (kind == 2) ? 2'($urandom_range(1, 3)) : 2'd0;
      addr  = (kind == 0) ? $urandom : (32'h80000000 | ($urandom & 32'h0000FFFF));
      wdata = $urandom;
      rdata = $urandom;
      wd    = 1'($urandom_range(0, 1));
      wreg  = 5'($urandom_range(0, 31));
      mis   = (kind != 0) && refMisalign(lt, st, addr);
      applyStimulus(lt, st, kind == 2, addr, wdata, wd, wreg);
      if (kind != 0 && !mis) begin
        checkOutput("rnd_addr", mem_addr_o, addr & 32'hFFFFFFFC);
        checkOutput("rnd_we", mem_we_o, (kind == 2));
        if (kind == 2) begin
          checkOutput("rnd_strb", mem_wstrb_o, refStrb(st, addr));
          checkOutput("rnd_sdata", mem_wdata_o, refStoreData(st, wdata));
        end
        runMemTxn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rdata);
      end else begin
        checkOutput("rnd_no_req", mem_req_o, 0);
      end
      expWd   = (kind == 2 || mis) ? 1'b0 : wd;
      expData = (kind == 0) ? addr : refLoad(lt, addr, rdata);
      expectOutput("rnd", expWd, wreg, expData, (kind != 2) && !mis, mis, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_lsu.md
YSYX_22041211_LSU -- requirements
Module: ysyx_22041211_lsu

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, meaning datapath and address width.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low (asserted at 0).
REQ-003 SHALL have upstream (EX) ports: valid_i in 1; ready_o out 1; wd_i in 1; wreg_i in 5; alu_result_i in DATA_LEN (result or address); mem_wen_i in 1; mem_wdata_i in DATA_LEN; store_type_i in 2; load_type_i in 3.
REQ-004 SHALL have downstream (WB) ports: valid_o out 1; ready_i in 1; wd_o out 1; wreg_o out 5; wdata_o out DATA_LEN (final register-write value).
REQ-005 SHALL have memory ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out DATA_LEN; mem_wdata_o out DATA_LEN; mem_wstrb_o out 4; mem_gnt_i in 1; mem_rvalid_i in 1; mem_rdata_i in DATA_LEN.

Function
REQ-006 SHALL encode load_type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU. SHALL encode store_type: 00 none, 01 SB, 10 SH, 11 SW.
REQ-007 SHALL implement FSM IDLE, REQ, WAIT. Output register (valid_o, wd_o, wreg_o, wdata_o) is separate from FSM.
REQ-008 SHALL drive ready_o = (state==IDLE) && (!valid_o || ready_i). Transfer occurs when valid_i && ready_o.
REQ-009 Non-memory op (load_type==0, mem_wen_i==0): on transfer, load output register next edge with wdata_o=alu_result_i; valid_o=1; 1-cycle latency.
REQ-010 Memory op: on transfer, latch op fields; go to REQ; mem_req_o=1 while in REQ, with address, we, data, strobe stable until mem_gnt_i.
REQ-011 REQ: gnt && !rvalid -> WAIT; gnt && rvalid same cycle -> IDLE with completion; !gnt -> stay.
REQ-012 WAIT: rvalid -> IDLE with completion; else stay. mem_rvalid_i in IDLE SHALL be ignored.
REQ-013 Completion: load -> output register gets extracted data, valid_o=1; store -> valid_o=1 with wd_o=0.
REQ-014 mem_addr_o SHALL be the address with bits [1:0] cleared; byte lane = addr[1:0].
REQ-015 Store strobes: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111. mem_wdata_o replicates byte/half across lanes.
REQ-016 Load extraction: select byte or half by addr[1:0]. LB sign-extends bit 7; LH sign-extends bit 15; LBU/LHU zero-extend; LW passes through.
REQ-017 valid_o held with stable data until ready_i; clears on consume unless a new completion loads the register in the same cycle.
REQ-018 SHALL accept at most one outstanding memory transaction.

Reset
REQ-019 rst low SHALL asynchronously set state=IDLE, valid_o=0, wd_o=0, wreg_o=0, wdata_o=0, mem_req_o=0, mem_we_o=0, mem_wstrb_o=0.
REQ-020 Reset mid-transaction SHALL abandon it; a subsequent rvalid in IDLE SHALL be ignored.

Configuration
REQ-021 Macro YSYX_22041211_LSU_MISALIGN_CHK_EN defined: adds output err_o (1). LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no memory request, complete in 1 cycle with valid_o=1, wd_o=0, and pulse err_o=1 with valid_o.
REQ-022 Macro undefined: no err_o port; misaligned accesses SHALL use the lane rules of REQ-015/016 unchanged.

Structure
REQ-023 Load/store type codes, strobe patterns, and FSM state encodings SHALL reside in the shared define file (ysyx_22041211_define.v).
REQ-024 Lane extraction/sign-extension SHALL be one combinational sub-module ysyx_22041211_lsu_align, shared with store lane replication.

Verification
REQ-025 Non-mem op: alu_result_i=0x12345678, wd_i=1, wreg_i=5 -> next cycle valid_o=1, wdata_o=0x12345678, wreg_o=5.
REQ-026 LB at 0x80000003, mem_rdata_i=0x80FF0000, gnt and rvalid one cycle later -> mem_addr_o=0x80000000, wdata_o=0xFFFFFF80.
REQ-027 LHU at 0x80000002, mem_rdata_i=0xBEEF1234, gnt delayed 3 cycles -> mem_req_o held 4 cycles, wdata_o=0x0000BEEF.
REQ-028 SB at 0x80000001, mem_wdata_i=0x000000AB -> mem_wstrb_o=0010, mem_wdata_o=0xABABABAB, mem_we_o=1, valid_o=1 with wd_o=0.
REQ-029 ready_i=0 for 5 cycles after completion -> valid_o and wdata_o stable, ready_o=0; rst low during WAIT -> mem_req_o=0, valid_o=0, later rvalid ignored.
REQ-030 With macro: LW at 0x80000002 -> no mem_req_o, err_o=1 one cycle after transfer.
